vram_arbiter: RTL and testbench

Single-port video RAM arbiter that shares one synchronous RAM between the text-mode display fetch and a system-side writer (CPU/loader) in the `clk_sys` domain. The display requester has priority so scanline fetches meet their deadline. A starvation counter guarantees the CPU a slot after a bounded wait. It sits between the text-mode renderer's tile/glyph fetch and the text-map RAM, so the text buffer can be updated while the display is running.

---
 rtl/vram_arbiter_if.sv | 51 +++++
 rtl/vram_arbiter.sv | 115 +++++++++++
 tb/tb_vram_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - request, return and RAM-port bundle for vram_arbiter
//
// Purpose: groups the display read port, the CPU access port and the RAM port.
//   slave  : the arbiter side (takes requests and mem_dout, drives acks, returns and RAM controls)
//   master : the requester/RAM side (the mirror image)
// Signals:
//   disp_req/disp_addr -> disp_ack, disp_rdata, disp_rvalid
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_ack, cpu_rdata, cpu_rvalid
//   mem_en/mem_we/mem_addr/mem_din -> RAM, mem_dout <- RAM (1-cycle read latency)
interface vram_arbiter_if #(
    parameter int ADDRW = 14,
    parameter int DATAW = 16
);
    logic             disp_req;
    logic [ADDRW-1:0] disp_addr;
    logic             disp_ack;
    logic [DATAW-1:0] disp_rdata;
    logic             disp_rvalid;

    logic             cpu_req;
    logic             cpu_we;
    logic [ADDRW-1:0] cpu_addr;
    logic [DATAW-1:0] cpu_wdata;
    logic             cpu_ack;
    logic [DATAW-1:0] cpu_rdata;
    logic             cpu_rvalid;

    logic             mem_en;
    logic             mem_we;
    logic [ADDRW-1:0] mem_addr;
    logic [DATAW-1:0] mem_din;
    logic [DATAW-1:0] mem_dout;

    modport slave (
        input  disp_req, disp_addr,
        output disp_ack, disp_rdata, disp_rvalid,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_rvalid,
        output mem_en, mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output disp_req, disp_addr,
        input  disp_ack, disp_rdata, disp_rvalid,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_rvalid,
        input  mem_en, mem_we, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter, display priority with CPU starvation guard
//
// Purpose: shares one synchronous RAM between the text-mode display fetch and
//   the system-side CPU/loader. The display normally wins; a CPU stalled for
//   STARVE_MAX consecutive cycles is given the next slot.
// Ports:
//   clk_sys      in   system clock
//   rst_sys_n    in   asynchronous active-low reset
//   bus          slave modport of vram_arbiter_if (display, CPU and RAM ports)
//   stall_count  out  16-bit saturating display stall counter (VRAM_ARB_STATS_EN only)
// Optional feature macro: VRAM_ARB_STATS_EN
module vram_arbiter #(
    parameter int ADDRW      = 14,
    parameter int DATAW      = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk_sys,
    input  logic          rst_sys_n,
    vram_arbiter_if.slave bus
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [15:0]   stall_count
`endif
);

    typedef enum logic {
        DISP_PRI = 1'b0,
        CPU_PRI  = 1'b1
    } state_t;

    localparam logic [7:0] STARVE_LAST = 8'(STARVE_MAX - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_starve_cnt;
    logic [7:0] w_starve_nxt;
    logic       w_disp_ack;
    logic       w_cpu_ack;
    logic       r_disp_rvalid;
    logic       r_cpu_rvalid;

    // Grant and next-state. Grants are held at 0 while reset is asserted so
    // the RAM port is quiet even with requests pending.
    always_comb begin
        w_disp_ack  = 1'b0;
        w_cpu_ack   = 1'b0;
        w_state_nxt = r_state;
        if (rst_sys_n) begin
            case (r_state)
                DISP_PRI: begin
                    w_disp_ack = bus.disp_req;
                    w_cpu_ack  = bus.cpu_req & ~bus.disp_req;
                    if (bus.cpu_req && !w_cpu_ack && r_starve_cnt == STARVE_LAST) begin
                        w_state_nxt = CPU_PRI;
                    end
                end
                CPU_PRI: begin
                    w_cpu_ack   = bus.cpu_req;
                    w_disp_ack  = bus.disp_req & ~bus.cpu_req;
                    // The CPU is either granted now or has withdrawn; both hand
                    // priority back to the display.
                    w_state_nxt = DISP_PRI;
                end
                default: w_state_nxt = DISP_PRI;
            endcase
        end
    end

    assign w_starve_nxt = (bus.cpu_req && !w_cpu_ack) ? (r_starve_cnt + 8'd1) : 8'd0;

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_state       <= DISP_PRI;
            r_starve_cnt  <= 8'd0;
            r_disp_rvalid <= 1'b0;
            r_cpu_rvalid  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_starve_cnt  <= w_starve_nxt;
            r_disp_rvalid <= w_disp_ack;
            r_cpu_rvalid  <= w_cpu_ack & ~bus.cpu_we;
        end
    end

    assign bus.disp_ack = w_disp_ack;
    assign bus.cpu_ack  = w_cpu_ack;

    // RAM port follows the winner; idle cycles drive zeros.
    assign bus.mem_en   = w_disp_ack | w_cpu_ack;
    assign bus.mem_we   = w_cpu_ack & bus.cpu_we;
    assign bus.mem_addr = w_disp_ack ? bus.disp_addr :
                          (w_cpu_ack ? bus.cpu_addr : '0);
    assign bus.mem_din  = w_cpu_ack ? bus.cpu_wdata : '0;

    // Both requesters see the RAM output directly; only rvalid qualifies it.
    assign bus.disp_rvalid = r_disp_rvalid;
    assign bus.cpu_rvalid  = r_cpu_rvalid;
    assign bus.disp_rdata  = rst_sys_n ? bus.mem_dout : '0;
    assign bus.cpu_rdata   = rst_sys_n ? bus.mem_dout : '0;

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_stall_count <= 16'd0;
        end else if (bus.disp_req && !w_disp_ack && r_stall_count != 16'hFFFF) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter
module tb_vram_arbiter;

    localparam int ADDRW = 14;
    localparam int DATAW = 16;

    logic clk_sys = 1'b0;
    logic rst_sys_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk_sys = ~clk_sys;

    vram_arbiter_if #(.ADDRW(ADDRW), .DATAW(DATAW)) bus ();

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stall_count;
`endif

    vram_arbiter #(.ADDRW(ADDRW), .DATAW(DATAW), .STARVE_MAX(4)) dut (
        .clk_sys     (clk_sys),
        .rst_sys_n   (rst_sys_n),
        .bus         (bus)
`ifdef VRAM_ARB_STATS_EN
        ,
        .stall_count (stall_count)
`endif
    );

    // Synchronous single-port RAM model, 1-cycle read latency.
    logic [DATAW-1:0] ram [0:(1<<ADDRW)-1];
    always @(posedge clk_sys) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
            else            bus.mem_dout <= ram[bus.mem_addr];
        end
    end

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle_inputs();
        bus.disp_req  = 1'b0;
        bus.disp_addr = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
    endtask

    task automatic test_reset();
        rst_sys_n     = 1'b0;
        bus.disp_req  = 1'b1;
        bus.disp_addr = 14'h0011;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 14'h0022;
        bus.cpu_wdata = 16'h5555;
        tick();
        tick();
        vectors++;
        if ({bus.disp_ack, bus.cpu_ack, bus.disp_rvalid, bus.cpu_rvalid, bus.mem_en, bus.mem_we} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b exp 000000", {bus.disp_ack, bus.cpu_ack, bus.disp_rvalid, bus.cpu_rvalid, bus.mem_en, bus.mem_we});
        end
        vectors++;
        if (bus.mem_addr !== 14'd0 || bus.mem_din !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_bus got addr %h din %h exp 0 0", bus.mem_addr, bus.mem_din);
        end
        idle_inputs();
        tick();
        rst_sys_n = 1'b1;
        tick();
    endtask

    // Loads ram[i] = i for i = 0..7 through the CPU port.
    task automatic test_cpu_preload();
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.cpu_req   = 1'b1;
            bus.cpu_we    = 1'b1;
            bus.cpu_addr  = 14'(i);
            bus.cpu_wdata = 16'(i);
            #1;
            vectors++;
            if (bus.cpu_ack !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 14'(i) || bus.mem_din !== 16'(i)) begin
                miscompares++;
                $display("FAIL preload[%0d] got ack %b we %b addr %h din %h exp 1 1 %h %h", i, bus.cpu_ack, bus.mem_we, bus.mem_addr, bus.mem_din, 14'(i), 16'(i));
            end
            vectors++;
            if (bus.cpu_rvalid !== 1'b0) begin
                miscompares++;
                $display("FAIL preload_no_rvalid[%0d] got %b exp 0", i, bus.cpu_rvalid);
            end
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (bus.cpu_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL preload_tail_rvalid got %b exp 0", bus.cpu_rvalid);
        end
    endtask

    task automatic test_disp_only();
        for (int k = 0; k < 10; k++) begin
            tick();
            bus.disp_req  = (k < 8);
            bus.disp_addr = (k < 8) ? 14'(k) : 14'd0;
            #1;
            vectors++;
            if (bus.disp_ack !== (k < 8) || bus.mem_en !== (k < 8) || bus.mem_we !== 1'b0) begin
                miscompares++;
                $display("FAIL disp_only_ack[%0d] got ack %b en %b we %b exp %b %b 0", k, bus.disp_ack, bus.mem_en, bus.mem_we, k < 8, k < 8);
            end
            vectors++;
            if (bus.disp_rvalid !== (k >= 1 && k <= 8)) begin
                miscompares++;
                $display("FAIL disp_only_rvalid[%0d] got %b exp %b", k, bus.disp_rvalid, (k >= 1 && k <= 8));
            end
            if (k >= 1 && k <= 8) begin
                vectors++;
                if (bus.disp_rdata !== 16'(k - 1)) begin
                    miscompares++;
                    $display("FAIL disp_only_rdata[%0d] got %h exp %h", k, bus.disp_rdata, 16'(k - 1));
                end
            end
        end
    endtask

    task automatic test_cpu_only();
        tick();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 14'h0100; bus.cpu_wdata = 16'hABCD;
        #1;
        vectors++;
        if (bus.cpu_ack !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 14'h0100 || bus.mem_din !== 16'hABCD) begin
            miscompares++;
            $display("FAIL cpu_write got ack %b we %b addr %h din %h exp 1 1 0100 abcd", bus.cpu_ack, bus.mem_we, bus.mem_addr, bus.mem_din);
        end
        tick();
        bus.cpu_we = 1'b0; bus.cpu_wdata = 16'h0000;
        #1;
        vectors++;
        if (bus.cpu_ack !== 1'b1 || bus.mem_we !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL cpu_read_ack got ack %b we %b rvalid %b exp 1 0 0", bus.cpu_ack, bus.mem_we, bus.cpu_rvalid);
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 16'hABCD) begin
            miscompares++;
            $display("FAIL cpu_read_data got rvalid %b data %h exp 1 abcd", bus.cpu_rvalid, bus.cpu_rdata);
        end
        tick();
        vectors++;
        if (bus.cpu_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL cpu_rvalid_drop got %b exp 0", bus.cpu_rvalid);
        end
    endtask

    task automatic test_starvation();
        for (int c = 0; c < 6; c++) begin
            tick();
            bus.disp_req = 1'b1; bus.disp_addr = 14'd1;
            bus.cpu_req = (c < 5); bus.cpu_we = 1'b0; bus.cpu_addr = 14'd5;
            #1;
            vectors++;
            if (bus.cpu_ack !== (c == 4) || bus.disp_ack !== (c != 4)) begin
                miscompares++;
                $display("FAIL starve_grant[%0d] got cpu %b disp %b exp %b %b", c, bus.cpu_ack, bus.disp_ack, c == 4, c != 4);
            end
            if (c == 4) begin
                vectors++;
                if (bus.mem_addr !== 14'd5) begin
                    miscompares++;
                    $display("FAIL starve_addr got %h exp 0005", bus.mem_addr);
                end
            end
            if (c == 5) begin
                vectors++;
                if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 16'd5 || bus.disp_rvalid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL starve_return got cpu_rvalid %b data %h disp_rvalid %b exp 1 0005 0", bus.cpu_rvalid, bus.cpu_rdata, bus.disp_rvalid);
                end
            end
        end
        tick();
        idle_inputs();
    endtask

    // CPU withdraws in the very cycle it was promoted; display keeps the slot
    // and the next CPU request starts a fresh starvation window.
    task automatic test_cpu_drop();
        for (int c = 0; c < 6; c++) begin
            tick();
            bus.disp_req = 1'b1; bus.disp_addr = 14'd2;
            bus.cpu_req = (c != 4); bus.cpu_we = 1'b0; bus.cpu_addr = 14'd6;
            #1;
            vectors++;
            if (bus.disp_ack !== 1'b1 || bus.cpu_ack !== 1'b0) begin
                miscompares++;
                $display("FAIL cpu_drop[%0d] got disp %b cpu %b exp 1 0", c, bus.disp_ack, bus.cpu_ack);
            end
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_coherency();
        tick();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 14'h0020; bus.cpu_wdata = 16'h1234;
        #1;
        vectors++;
        if (bus.cpu_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL coh_write_ack got %b exp 1", bus.cpu_ack);
        end
        tick();
        idle_inputs();
        bus.disp_req = 1'b1; bus.disp_addr = 14'h0020;
        #1;
        vectors++;
        if (bus.disp_ack !== 1'b1 || bus.mem_addr !== 14'h0020) begin
            miscompares++;
            $display("FAIL coh_read_ack got ack %b addr %h exp 1 0020", bus.disp_ack, bus.mem_addr);
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (bus.disp_rvalid !== 1'b1 || bus.disp_rdata !== 16'h1234) begin
            miscompares++;
            $display("FAIL coh_read_data got rvalid %b data %h exp 1 1234", bus.disp_rvalid, bus.disp_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        // Four contended cycles: display read granted in the last one, CPU due next.
        for (int c = 0; c < 4; c++) begin
            tick();
            bus.disp_req = 1'b1; bus.disp_addr = 14'd3;
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'd7;
        end
        #1;
        vectors++;
        if (bus.disp_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_pre_ack got %b exp 1", bus.disp_ack);
        end
        #1;
        rst_sys_n = 1'b0;
        #1;
        vectors++;
        if (bus.disp_ack !== 1'b0 || bus.cpu_ack !== 1'b0 || bus.mem_en !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_force got disp %b cpu %b en %b exp 0 0 0", bus.disp_ack, bus.cpu_ack, bus.mem_en);
        end
        tick();
        vectors++;
        if ({bus.disp_rvalid, bus.cpu_rvalid, bus.mem_en, bus.mem_we} !== 4'b0 || bus.mem_addr !== 14'd0 || bus.mem_din !== 16'd0 || bus.disp_rdata !== 16'd0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs got rv %b%b en %b we %b addr %h din %h rdata %h exp all 0", bus.disp_rvalid, bus.cpu_rvalid, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din, bus.disp_rdata);
        end
        // Release with both still requesting: DISP_PRI and a cleared starvation count.
        for (int c = 0; c < 5; c++) begin
            tick();
            rst_sys_n = 1'b1;
            #1;
            vectors++;
            if (bus.disp_ack !== (c != 4) || bus.cpu_ack !== (c == 4)) begin
                miscompares++;
                $display("FAIL rst_mid_after[%0d] got disp %b cpu %b exp %b %b", c, bus.disp_ack, bus.cpu_ack, c != 4, c == 4);
            end
        end
        tick();
        idle_inputs();
        tick();
    endtask

`ifdef VRAM_ARB_STATS_EN
    task automatic test_stats();
        tick();
        rst_sys_n = 1'b0;
        tick();
        rst_sys_n = 1'b1;
        #1;
        vectors++;
        if (stall_count !== 16'd0) begin
            miscompares++;
            $display("FAIL stats_reset got %0d exp 0", stall_count);
        end
        // 10 contended cycles with STARVE_MAX=4: CPU wins cycles 4 and 9.
        for (int c = 0; c < 10; c++) begin
            tick();
            bus.disp_req = 1'b1; bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
            if (c == 5) begin
                #1;
                vectors++;
                if (stall_count !== 16'd1) begin
                    miscompares++;
                    $display("FAIL stats_mid got %0d exp 1", stall_count);
                end
            end
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (stall_count !== 16'd2) begin
            miscompares++;
            $display("FAIL stats_end got %0d exp 2", stall_count);
        end
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_cpu_preload();
        test_disp_only();
        test_cpu_only();
        test_starvation();
        test_cpu_drop();
        test_coherency();
        test_reset_mid_read();
`ifdef VRAM_ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
